// File: rtl/tl_phase_scheduler.sv
// Round-robin GREEN/YELLOW/ALLRED phase scheduler with min/max green and clearance timing.
// Optional emergency preemption (emg_req/emg_id) is built when TL_PREEMPT_EN is defined.
module tl_phase_scheduler #(
    parameter int unsigned N_APPR      = 4,
    parameter int unsigned TICK_DIV    = 4,
    parameter int unsigned T_MIN_GREEN = 5,
    parameter int unsigned T_MAX_GREEN = 10,
    parameter int unsigned T_YELLOW    = 3,
    parameter int unsigned T_ALLRED    = 1,
    parameter int unsigned CW          = 8
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [N_APPR-1:0]         req,
`ifdef TL_PREEMPT_EN
    input  logic                      emg_req,
    input  logic [$clog2(N_APPR)-1:0] emg_id,
`endif
    output logic [N_APPR-1:0]         green,
    output logic [N_APPR-1:0]         yellow,
    output logic [N_APPR-1:0]         red,
    output logic [$clog2(N_APPR)-1:0] cur_id,
    output logic                      busy
);

    localparam int unsigned IdW = $clog2(N_APPR);

    localparam logic [CW-1:0] DivLast = CW'(TICK_DIV - 1);
    localparam logic [CW:0]   TMinG   = (CW+1)'(T_MIN_GREEN);
    localparam logic [CW:0]   TMaxG   = (CW+1)'(T_MAX_GREEN);
    localparam logic [CW:0]   TYel    = (CW+1)'(T_YELLOW);
    localparam logic [CW:0]   TAr     = (CW+1)'(T_ALLRED);
    localparam logic [IdW:0]  NAppr   = (IdW+1)'(N_APPR);

    typedef enum logic [1:0] {
        StIdle,
        StGreen,
        StYellow,
        StAllred
    } state_e;

    state_e             state_q, state_d;
    logic [IdW-1:0]     cur_id_q, cur_id_d;
    logic [IdW-1:0]     ptr_q, ptr_d;
    logic [CW-1:0]      div_q, div_d;
    logic [CW-1:0]      tmr_q, tmr_d;
    logic [N_APPR-1:0]  green_q, green_d;
    logic [N_APPR-1:0]  yellow_q, yellow_d;
    logic [N_APPR-1:0]  red_q, red_d;
    logic               busy_q, busy_d;

    logic               tick;
    logic [CW:0]        tmr_inc;
    logic [N_APPR-1:0]  others_mask;
    logic               others;
    logic               win_vld;
    logic [IdW-1:0]     win_id;
    logic [IdW:0]       scan;

`ifdef TL_PREEMPT_EN
    logic               emg_pend_q, emg_pend_d;
    logic [IdW-1:0]     emg_pid_q, emg_pid_d;
`endif

    assign tick    = (div_q == DivLast);
    assign tmr_inc = {1'b0, tmr_q} + (CW+1)'(1);

    // Round-robin scan starting just after the last grant; the last grant is checked last.
    always_comb begin
        win_vld = 1'b0;
        win_id  = ptr_q;
        scan    = '0;
        for (int unsigned k = 1; k <= N_APPR; k++) begin
            scan = {1'b0, ptr_q} + (IdW+1)'(k);
            if (scan >= NAppr) begin
                scan = scan - NAppr;
            end
            if (!win_vld && req[scan[IdW-1:0]]) begin
                win_vld = 1'b1;
                win_id  = scan[IdW-1:0];
            end
        end
    end

    always_comb begin
        others_mask           = req;
        others_mask[cur_id_q] = 1'b0;
        others                = |others_mask;
    end

    always_comb begin
        state_d  = state_q;
        cur_id_d = cur_id_q;
        ptr_d    = ptr_q;
`ifdef TL_PREEMPT_EN
        emg_pend_d = emg_pend_q;
        emg_pid_d  = emg_pid_q;
`endif
        unique case (state_q)
            StIdle: begin
                if (win_vld) begin
                    state_d  = StGreen;
                    cur_id_d = win_id;
                    ptr_d    = win_id;
                end
            end
            StGreen: begin
                if (tick && others &&
                    ((tmr_inc >= TMaxG) || ((tmr_inc >= TMinG) && !req[cur_id_q]))) begin
                    state_d = StYellow;
                end
            end
            StYellow: begin
                if (tick && (tmr_inc >= TYel)) begin
                    state_d = StAllred;
                end
            end
            StAllred: begin
                if (tick && (tmr_inc >= TAr)) begin
                    if (win_vld) begin
                        state_d  = StGreen;
                        cur_id_d = win_id;
                        ptr_d    = win_id;
                    end else begin
                        state_d = StIdle;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
`ifdef TL_PREEMPT_EN
        // Emergency overrides the round-robin decision made above.
        unique case (state_q)
            StIdle: begin
                if (emg_req) begin
                    state_d  = StGreen;
                    cur_id_d = emg_id;
                    ptr_d    = emg_id;
                end
            end
            StGreen: begin
                if (emg_req) begin
                    if (emg_id != cur_id_q) begin
                        state_d    = StYellow;
                        emg_pend_d = 1'b1;
                        emg_pid_d  = emg_id;
                    end else begin
                        state_d = StGreen;
                    end
                end
            end
            StYellow: begin
                if (emg_req) begin
                    emg_pend_d = 1'b1;
                    emg_pid_d  = emg_id;
                end
            end
            StAllred: begin
                if (emg_req) begin
                    emg_pend_d = 1'b1;
                    emg_pid_d  = emg_id;
                end
                if (tick && (tmr_inc >= TAr) && (emg_req || emg_pend_q)) begin
                    state_d  = StGreen;
                    cur_id_d = emg_req ? emg_id : emg_pid_q;
                    ptr_d    = emg_req ? emg_id : emg_pid_q;
                end
            end
            default: ;
        endcase
        if (state_d == StGreen) begin
            emg_pend_d = 1'b0;
        end
`endif
    end

    // Divider and phase timer restart on every state change so phase lengths are exact.
    always_comb begin
        div_d = div_q;
        tmr_d = tmr_q;
        if ((state_d != state_q) || (state_q == StIdle)) begin
            div_d = '0;
            tmr_d = '0;
        end else if (tick) begin
            div_d = '0;
            if ((state_q == StGreen) && (tmr_inc > TMaxG)) begin
                tmr_d = TMaxG[CW-1:0];
            end else begin
                tmr_d = tmr_inc[CW-1:0];
            end
        end else begin
            div_d = div_q + CW'(1);
        end
    end

    // Lamps are decoded from next state so they switch on the same edge as the FSM.
    always_comb begin
        green_d  = '0;
        yellow_d = '0;
        if (state_d == StGreen) begin
            green_d[cur_id_d] = 1'b1;
        end
        if (state_d == StYellow) begin
            yellow_d[cur_id_d] = 1'b1;
        end
        red_d  = ~(green_d | yellow_d);
        busy_d = (state_d != StIdle);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= StIdle;
            cur_id_q <= '0;
            ptr_q    <= IdW'(N_APPR - 1);
            div_q    <= '0;
            tmr_q    <= '0;
            green_q  <= '0;
            yellow_q <= '0;
            red_q    <= '1;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cur_id_q <= cur_id_d;
            ptr_q    <= ptr_d;
            div_q    <= div_d;
            tmr_q    <= tmr_d;
            green_q  <= green_d;
            yellow_q <= yellow_d;
            red_q    <= red_d;
            busy_q   <= busy_d;
        end
    end

`ifdef TL_PREEMPT_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            emg_pend_q <= 1'b0;
            emg_pid_q  <= '0;
        end else begin
            emg_pend_q <= emg_pend_d;
            emg_pid_q  <= emg_pid_d;
        end
    end
`endif

    assign green  = green_q;
    assign yellow = yellow_q;
    assign red    = red_q;
    assign cur_id = cur_id_q;
    assign busy   = busy_q;

endmodule

// File: tb/tb_tl_phase_scheduler.sv
// Directed bench for tl_phase_scheduler (default parameters: 4 approaches, TICK_DIV=4).
// Emergency scenario is included when TL_PREEMPT_EN is defined.
module tb_tl_phase_scheduler;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [3:0] req = 4'b0000;
    logic [3:0] green;
    logic [3:0] yellow;
    logic [3:0] red;
    logic [1:0] cur_id;
    logic       busy;
`ifdef TL_PREEMPT_EN
    logic       emg_req = 1'b0;
    logic [1:0] emg_id  = 2'd0;
`endif

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    tl_phase_scheduler dut (
        .clk    (clk),
        .rst    (rst),
        .req    (req),
`ifdef TL_PREEMPT_EN
        .emg_req(emg_req),
        .emg_id (emg_id),
`endif
        .green  (green),
        .yellow (yellow),
        .red    (red),
        .cur_id (cur_id),
        .busy   (busy)
    );

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        rst = 1'b0;
        req = 4'b0000;
`ifdef TL_PREEMPT_EN
        emg_req = 1'b0;
        emg_id  = 2'd0;
`endif
        step(2);
        rst = 1'b1;
    endtask

    initial begin
        // Reset values, then idle with no requests
        step(2);
        chk("rst_red", 32'(red), 32'hF);
        chk("rst_green", 32'(green), 32'h0);
        chk("rst_yellow", 32'(yellow), 32'h0);
        chk("rst_busy", 32'(busy), 32'h0);
        chk("rst_cur_id", 32'(cur_id), 32'h0);
        rst = 1'b1;
        step(100);
        chk("idle_red", 32'(red), 32'hF);
        chk("idle_busy", 32'(busy), 32'h0);
        chk("idle_green", 32'(green), 32'h0);

        // Single request: green one clk later, held with nobody else waiting
        req = 4'b0001;
        step(1);
        chk("solo_green", 32'(green), 32'h1);
        chk("solo_red", 32'(red), 32'hE);
        chk("solo_busy", 32'(busy), 32'h1);
        chk("solo_cur_id", 32'(cur_id), 32'h0);
        step(200);
        chk("solo_hold_green", 32'(green), 32'h1);
        chk("solo_hold_yellow", 32'(yellow), 32'h0);

        // Max-out: green 40, yellow 12, all-red 4, then approach 1
        do_reset();
        req = 4'b0001;
        step(1);
        chk("mx_green_start", 32'(green), 32'h1);
        step(1);
        req = 4'b0011;
        step(38);
        chk("mx_green_last", 32'(green), 32'h1);
        step(1);
        chk("mx_yellow_start", 32'(yellow), 32'h1);
        chk("mx_green_off", 32'(green), 32'h0);
        step(11);
        chk("mx_yellow_last", 32'(yellow), 32'h1);
        step(1);
        chk("mx_allred_red", 32'(red), 32'hF);
        chk("mx_allred_busy", 32'(busy), 32'h1);
        step(3);
        chk("mx_allred_last", 32'(red), 32'hF);
        step(1);
        chk("mx_next_green", 32'(green), 32'h2);
        chk("mx_next_cur_id", 32'(cur_id), 32'h1);

        // Gap-out at min green; also shows approach 0 wins first after reset
        do_reset();
        req = 4'b0011;
        step(1);
        chk("gap_first_green", 32'(green), 32'h1);
        step(7);
        req = 4'b0010;
        step(12);
        chk("gap_green_last", 32'(green), 32'h1);
        step(1);
        chk("gap_yellow_start", 32'(yellow), 32'h1);

        // All requesting: grant order 0,1,2,3,0 every 56 cycles
        do_reset();
        req = 4'b1111;
        step(1);
        chk("rr_grant_0", 32'(green), 32'h1);
        for (int i = 1; i <= 4; i++) begin
            step(56);
            chk("rr_grant_green", 32'(green), 32'(4'b0001 << (i % 4)));
            chk("rr_grant_cur_id", 32'(cur_id), 32'(i % 4));
        end
        step(40);
        chk("rr_yellow0", 32'(yellow), 32'h1);
        step(5);
        rst = 1'b0;
        #1;
        chk("midrst_red", 32'(red), 32'hF);
        chk("midrst_green", 32'(green), 32'h0);
        chk("midrst_yellow", 32'(yellow), 32'h0);
        chk("midrst_busy", 32'(busy), 32'h0);
        chk("midrst_cur_id", 32'(cur_id), 32'h0);
        step(1);
        rst = 1'b1;

`ifdef TL_PREEMPT_EN
        // Preempt green 0 for approach 2
        do_reset();
        req = 4'b0001;
        step(1);
        chk("emg_green0", 32'(green), 32'h1);
        emg_req = 1'b1;
        emg_id  = 2'd2;
        step(1);
        chk("emg_yellow0", 32'(yellow), 32'h1);
        step(11);
        chk("emg_yellow_last", 32'(yellow), 32'h1);
        step(1);
        chk("emg_allred", 32'(red), 32'hF);
        step(3);
        chk("emg_allred_last", 32'(red), 32'hF);
        step(1);
        chk("emg_green2", 32'(green), 32'h4);
        chk("emg_cur_id", 32'(cur_id), 32'h2);
        step(100);
        chk("emg_hold", 32'(green), 32'h4);
        emg_req = 1'b0;
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/tl_phase_scheduler.md
# tl_phase_scheduler

Round-robin phase scheduler for a multi-approach signalised intersection. It shares the single right-of-way resource among N_APPR approach sensors, sequencing each grant through GREEN, YELLOW and ALL-RED with minimum-green, maximum-green and clearance timing. Timing comes from an internal clock-enable tick divider. It sits above the per-approach lamp drivers and replaces hard-wired two-road sequencing.

## Interface
- N_APPR, 4: number of approaches; range 2..8.
- TICK_DIV, 4: clk cycles per timing tick; must be ≥2.
- T_MIN_GREEN, 5: minimum green, in ticks; must be ≥1.
- T_MAX_GREEN, 10: maximum green when others are waiting, in ticks; must be ≥ T_MIN_GREEN.
- T_YELLOW, 3: yellow duration, in ticks; must be ≥1.
- T_ALLRED, 1: all-red clearance, in ticks; must be ≥1.
- CW, 8: width of the tick divider and phase timer; every T_* value and TICK_DIV must be < 2^CW.
- clk  in  1  clock.
- rst  in  1  reset, asynchronous, active-low.
- req  in  N_APPR  level vehicle-presence per approach, synchronous to clk.
- green  out  N_APPR  one-hot or zero; green lamp per approach.
- yellow  out  N_APPR  one-hot or zero; yellow lamp per approach.
- red  out  N_APPR  equals ~(green|yellow).
- cur_id  out  clog2(N_APPR)  approach currently or last granted.
- busy  out  1  high in every state except IDLE.
- emg_req  in  1  emergency preempt request. Present only with TL_PREEMPT_EN.
- emg_id  in  clog2(N_APPR)  approach to preempt to. Present only with TL_PREEMPT_EN.

## Operation
- States: IDLE, GREEN, YELLOW, ALLRED. All outputs are registered and decoded from state and cur_id.
- In GREEN, green[cur_id]=1. In YELLOW, yellow[cur_id]=1. In IDLE and ALLRED, all lamps are red.
- Reset values: state=IDLE, cur_id=0, green=0, yellow=0, red=all ones, busy=0.
- On reset, the round-robin pointer is N_APPR-1, so approach 0 has top priority first.
- Arbitration picks the first asserted req scanning from cur_id+1 upward, with wrap. The just-served approach has lowest priority.
- "others" means any req[j] with j≠cur_id.
- IDLE → GREEN: on the first clk edge where req≠0. cur_id becomes the winner.
- GREEN → YELLOW happens on a tick edge, with n = ticks elapsed in GREEN including this one, when both of these hold:
  - others pending, and
  - either n ≥ T_MAX_GREEN (max-out), or n ≥ T_MIN_GREEN and req[cur_id]=0 (gap-out).
- GREEN with no others pending holds indefinitely. The phase timer saturates at T_MAX_GREEN.
- YELLOW → ALLRED: after T_YELLOW ticks.
- ALLRED → GREEN (new winner) after T_ALLRED ticks if any req is set. cur_id itself is eligible, at lowest priority. Otherwise ALLRED → IDLE.
- req is sampled at each edge. A req change coincident with a tick uses the value sampled at that edge.
- Reset asserted mid-phase immediately forces the reset values. There is no yellow or clearance on reset.

## Timing
- The tick divider counts 0..TICK_DIV-1. tick=1 when the count is TICK_DIV-1.
- The divider and phase timer clear on every state change, so phase durations are exact:
  - YELLOW = T_YELLOW·TICK_DIV cycles.
  - ALLRED = T_ALLRED·TICK_DIV cycles.
  - GREEN ≥ T_MIN_GREEN·TICK_DIV cycles.
- IDLE→GREEN latency is 1 clk after req is sampled high.
- Lamp outputs change on the same edge as the state register. Lamps never glitch.

## Configuration
- Macro: TL_PREEMPT_EN.
- Defined: the emg_req and emg_id ports exist.
  - If emg_req=1 in GREEN with cur_id≠emg_id, go to YELLOW on the next edge, ignoring min green.
  - YELLOW and ALLRED always complete. ALLRED then grants emg_id regardless of req or round-robin.
  - From IDLE, emg_req goes straight to GREEN with cur_id=emg_id.
  - GREEN on emg_id holds while emg_req=1 (no max-out). Normal rules resume once emg_req drops.
- Undefined: the ports are absent and scheduling is pure round-robin.

## Test plan
- Reset, req=0 for 100 cycles → red=4'b1111, green=yellow=0, busy=0, cur_id=0.
- req=4'b0001 held → green=4'b0001 one clk later; still green after 200 cycles.
- req=4'b0001, then 4'b0011 from green cycle 2 → green0 lasts 40 cycles (max-out), then yellow0 12 cycles, all-red 4 cycles, then green=4'b0010.
- req=4'b0011, req[0] dropped at green cycle 8 → yellow0 starts exactly at green cycle 20 (gap-out at min green).
- req=4'b1111 held → grant order 0,1,2,3,0. rst pulsed low mid-YELLOW → red=4'b1111 on the same cycle.
- TL_PREEMPT_EN: green0 active at green cycle 1, emg_req=1 with emg_id=2 → yellow0 on the next edge, then 12+4 cycles, then green=4'b0100, held while emg_req=1 for 100 cycles.
